rob_commit_ctrl: RTL and testbench
==================================

# rob_commit_ctrl

Sequencing controller for the reorder buffer's array of per-entry slots. Owns the enqueue (tail) and commit (head) pointers, drives each entry's enq/commit/flush strobes, and retires one completed entry per cycle in program order. It also serialises committed branch-predictor (BHT/BTB) updates through a one-deep buffer, so a busy predictor write port back-pressures commit rather than dropping updates.

## Interface
Parameters:
- DEPTH, 8, number of ROB entries; power of two, ≥2
- IDX_W, $clog2(DEPTH), entry index width
- UPD_W, 280, width of the opaque packed predictor-update payload (BHT and BTB fields)

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enq_req  in  1  rename stage offers one instruction
- enq_ready  out  1  ROB can accept (not full)
- enq_idx  out  IDX_W  tail index the offered instruction will occupy
- entry_enq_valid  out  DEPTH  one-hot enq strobe to entries
- entry_ready_to_commit  in  DEPTH  per-entry valid&complete
- head_idx  out  IDX_W  current head; external mux selects head payload
- head_upd_en  in  1  muxed head entry has a predictor write (bht_write_enable | btb_we)
- head_upd_data  in  UPD_W  muxed head predictor payload
- entry_commit_vld  out  DEPTH  one-hot commit strobe to entries
- commit_valid  out  1  an entry retires this cycle
- commit_idx  out  IDX_W  index retiring (equals head_idx)
- flush_vld  in  1  pipeline flush request
- entry_flush_vld  out  1  broadcast flush to all entries
- upd_valid  out  1  buffered predictor update pending
- upd_ready  in  1  predictor write port accepts
- upd_data  out  UPD_W  buffered predictor payload
- count  out  IDX_W+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Pointers head_ptr/tail_ptr are IDX_W+1 bits (wrap bit MSB); index = low IDX_W bits. full when indices equal and wrap bits differ; empty when pointers equal.
- enq_ready = ~full (from registered state only; a same-cycle commit does not free space for enqueue).
- enq_fire = enq_req & enq_ready & ~flush_vld. entry_enq_valid = enq_fire ? onehot(tail idx) : 0. tail_ptr += 1 on enq_fire.
- upd_slot_free = ~upd_valid | upd_ready.
- commit_fire = entry_ready_to_commit[head idx] & ~empty & ~flush_vld & (~head_upd_en | upd_slot_free). entry_commit_vld = commit_fire ? onehot(head idx) : 0. head_ptr += 1 on commit_fire.
- count: +1 on enq_fire only, −1 on commit_fire only, unchanged on both or neither.
- Predictor buffer: on commit_fire & head_upd_en, upd_valid←1, upd_data←head_upd_data (load wins over drain). Else if upd_ready, upd_valid←0. upd_data is held while upd_valid & ~upd_ready.
- Flush: entry_flush_vld = flush_vld (combinational). At next edge head_ptr, tail_ptr, count ← 0. Buffered predictor update is architectural and is NOT cleared by flush.
- Reset: head_ptr, tail_ptr, count, upd_valid, upd_data ← 0. Hence enq_ready=1, empty=1, full=0, all strobes 0.

## Timing
- Enqueue: entry captures on the edge ending the enq_fire cycle; its ready_to_commit can rise no earlier than the following cycle.
- Commit: combinational from entry_ready_to_commit; entry clears and head advances on the same edge. Back-to-back commits every cycle when consecutive entries are ready.
- Update path: upd_valid rises the cycle after the committing cycle; held until upd_ready is sampled high.
- flush_vld dominates: no enq or commit strobe in a flush cycle; pointers read 0 the next cycle.
- Reset asserted mid-operation clears all state immediately (async), including a pending update.

## Test plan
- Reset, then 8 enqueues (DEPTH=8): enq_idx 0..7, count 8, full=1, enq_ready=0; 9th enq_req produces no strobe.
- Full ROB, ready_to_commit[0]=1 with enq_req=1 same cycle: commit_idx=0 fires, no enqueue; count 7; next cycle enq lands at idx 0 (wrap), tail wrap bit toggles.
- Head ready out of order: ready_to_commit=8'b0000_0010 with head=0 → no commit; after bit0 set → commits 0 then 1 on consecutive cycles.
- Predictor back-pressure: two consecutive heads with head_upd_en=1, upd_ready=0 → first commits, upd_valid=1, second stalls; upd_ready=1 one cycle → second commits same cycle, upd_data replaced.
- Flush with 5 entries and upd_valid=1: entry_flush_vld=1 that cycle, no commit despite ready head; next cycle count=0, empty=1, upd_valid still 1 with unchanged upd_data.
- Async reset pulse mid-stream with pending update: all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: ROB head/tail sequencing with in-order commit and a one-deep predictor update buffer
module rob_commit_ctrl #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int UPD_W = 280
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_req,
    output logic             enq_ready,
    output logic [IDX_W-1:0] enq_idx,
    output logic [DEPTH-1:0] entry_enq_valid,
    input  logic [DEPTH-1:0] entry_ready_to_commit,
    output logic [IDX_W-1:0] head_idx,
    input  logic             head_upd_en,
    input  logic [UPD_W-1:0] head_upd_data,
    output logic [DEPTH-1:0] entry_commit_vld,
    output logic             commit_valid,
    output logic [IDX_W-1:0] commit_idx,
    input  logic             flush_vld,
    output logic             entry_flush_vld,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [UPD_W-1:0] upd_data,
    output logic [IDX_W:0]   count,
    output logic             full,
    output logic             empty
);
    localparam logic [IDX_W:0]   one = 1;
    localparam logic [DEPTH-1:0] bit0 = 1;
    logic [IDX_W:0]   head_ptr, tail_ptr;
    logic [IDX_W-1:0] tail_i;
    logic             enq_fire, commit_fire, upd_slot_free;
    assign head_idx        = head_ptr[IDX_W-1:0];
    assign tail_i          = tail_ptr[IDX_W-1:0];
    assign enq_idx         = tail_i;
    assign commit_idx      = head_idx;
    assign full            = (head_idx == tail_i) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);
    assign empty           = head_ptr == tail_ptr;
    assign enq_ready       = ~full;
    assign entry_flush_vld = flush_vld;
    assign upd_slot_free   = ~upd_valid | upd_ready;
    assign commit_valid    = commit_fire;
    // Fire decisions and one-hot strobes; flush suppresses both sides
    always_comb begin
        enq_fire         = enq_req & enq_ready & ~flush_vld;
        commit_fire      = entry_ready_to_commit[head_idx] & ~empty & ~flush_vld
                           & (~head_upd_en | upd_slot_free);
        entry_enq_valid  = enq_fire ? bit0 << tail_i : '0;
        entry_commit_vld = commit_fire ? bit0 << head_idx : '0;
    end
    // Pointer and occupancy state; flush empties the ROB
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush_vld) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq_fire) tail_ptr <= tail_ptr + one;
            if (commit_fire) head_ptr <= head_ptr + one;
            if (enq_fire != commit_fire) count <= enq_fire ? count + one : count - one;
        end
    end
    // Predictor update buffer; architectural, so it survives flush and a new load beats a drain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid <= 1'b0;
            upd_data  <= '0;
        end else if (commit_fire && head_upd_en) begin
            upd_valid <= 1'b1;
            upd_data  <= head_upd_data;
        end else if (upd_ready) begin
            upd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: scoreboard bench for commit order and predictor update delivery
module tb_rob_commit_ctrl;
    typedef logic [279:0] w_t;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         enq_req = 1'b0;
    logic         enq_ready;
    logic [2:0]   enq_idx;
    logic [7:0]   entry_enq_valid;
    logic [7:0]   entry_ready_to_commit = '0;
    logic [2:0]   head_idx;
    logic         head_upd_en = 1'b0;
    w_t           head_upd_data = '0;
    logic [7:0]   entry_commit_vld;
    logic         commit_valid;
    logic [2:0]   commit_idx;
    logic         flush_vld = 1'b0;
    logic         entry_flush_vld;
    logic         upd_valid;
    logic         upd_ready = 1'b0;
    w_t           upd_data;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    int           checks = 0;
    int           errors = 0;
    int           exp_q[$];
    w_t           upd_q[$];
    w_t           d1, d2, d3;

    rob_commit_ctrl #(.DEPTH(8), .IDX_W(3), .UPD_W(280)) dut (
        .clock(clock), .reset_n(reset_n), .enq_req(enq_req), .enq_ready(enq_ready),
        .enq_idx(enq_idx), .entry_enq_valid(entry_enq_valid),
        .entry_ready_to_commit(entry_ready_to_commit), .head_idx(head_idx),
        .head_upd_en(head_upd_en), .head_upd_data(head_upd_data),
        .entry_commit_vld(entry_commit_vld), .commit_valid(commit_valid),
        .commit_idx(commit_idx), .flush_vld(flush_vld), .entry_flush_vld(entry_flush_vld),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_data(upd_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input w_t got, input w_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, w_t'(count), 0);
        chk({tag, "_empty"}, w_t'(empty), 1);
        chk({tag, "_full"}, w_t'(full), 0);
        chk({tag, "_enq_ready"}, w_t'(enq_ready), 1);
        chk({tag, "_upd_valid"}, w_t'(upd_valid), 0);
        chk({tag, "_upd_data"}, upd_data, 0);
        chk({tag, "_head"}, w_t'(head_idx), 0);
        chk({tag, "_strobes"}, w_t'({entry_enq_valid, entry_commit_vld}), 0);
    endtask

    // Commit and update monitor, sampled mid-cycle against the scoreboard queues
    always @(negedge clock) begin
        if (reset_n) begin
            if (commit_valid) begin
                if (exp_q.size() == 0) chk("commit_extra", w_t'(commit_valid), 0);
                else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("commit_idx", w_t'(commit_idx), w_t'(e));
                    chk("commit_onehot", w_t'(entry_commit_vld), w_t'(1) << e);
                end
            end
            if (upd_valid && upd_ready) begin
                if (upd_q.size() == 0) chk("upd_extra", w_t'(upd_valid), 0);
                else chk("upd_data", upd_data, upd_q.pop_front());
            end
        end
    end

    initial begin
        d1 = {8{35'h1_2345_6789}};
        d2 = {8{35'h5_5AA5_0F0F}};
        d3 = {8{35'h3_1337_BEEF}};
        repeat (2) cyc();
        chk_reset_state("rst");
        reset_n = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            enq_req = 1'b1;
            #3;
            chk("enq_idx", w_t'(enq_idx), w_t'(i));
            chk("enq_strobe", w_t'(entry_enq_valid), w_t'(1) << i);
            exp_q.push_back(i);
            cyc();
        end
        #3;
        chk("full_count", w_t'(count), 8);
        chk("full_flag", w_t'({full, enq_ready}), 2'b10);
        chk("full_no_enq", w_t'(entry_enq_valid), 0);
        cyc();
        entry_ready_to_commit = 8'h01;
        #3;
        chk("full_commit", w_t'(commit_valid), 1);
        chk("full_commit_no_enq", w_t'(entry_enq_valid), 0);
        cyc();
        entry_ready_to_commit = 8'h00;
        #3;
        chk("after_commit_count", w_t'(count), 7);
        chk("wrap_enq_idx", w_t'(enq_idx), 0);
        chk("wrap_enq_strobe", w_t'(entry_enq_valid), 1);
        exp_q.push_back(0);
        cyc();
        enq_req = 1'b0;
        #3;
        chk("wrap_full", w_t'({full, head_idx, count}), {1'b1, 3'd1, 4'd8});
        entry_ready_to_commit = 8'b0000_0100;
        #1;
        chk("ooo_no_commit", w_t'(commit_valid), 0);
        cyc();
        entry_ready_to_commit = 8'b0000_0110;
        #3;
        chk("ooo_commit1", w_t'(commit_valid), 1);
        cyc();
        #3;
        chk("ooo_commit2", w_t'({commit_valid, head_idx}), {1'b1, 3'd2});
        cyc();
        entry_ready_to_commit = 8'b0001_1000;
        head_upd_en = 1'b1;
        head_upd_data = d1;
        #3;
        chk("ooo_count", w_t'(count), 6);
        chk("upd_commit1", w_t'(commit_valid), 1);
        upd_q.push_back(d1);
        cyc();
        head_upd_data = d2;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("upd_stall", w_t'(commit_valid), 0);
            chk("upd_hold_v", w_t'(upd_valid), 1);
            chk("upd_hold_d", upd_data, d1);
            cyc();
        end
        upd_ready = 1'b1;
        #3;
        chk("upd_commit2", w_t'(commit_valid), 1);
        upd_q.push_back(d2);
        cyc();
        upd_ready = 1'b0;
        head_upd_en = 1'b0;
        entry_ready_to_commit = 8'h00;
        enq_req = 1'b1;
        #3;
        chk("upd_replaced", upd_data, d2);
        chk("upd_still_v", w_t'(upd_valid), 1);
        chk("enq_idx1", w_t'(enq_idx), 1);
        exp_q.push_back(1);
        cyc();
        enq_req = 1'b1;
        flush_vld = 1'b1;
        entry_ready_to_commit = 8'b0010_0000;
        #3;
        chk("flush_count_pre", w_t'(count), 5);
        chk("flush_bcast", w_t'(entry_flush_vld), 1);
        chk("flush_no_commit", w_t'(commit_valid), 0);
        chk("flush_no_enq", w_t'(entry_enq_valid), 0);
        cyc();
        flush_vld = 1'b0;
        enq_req = 1'b0;
        entry_ready_to_commit = 8'h00;
        exp_q.delete();
        #3;
        chk("flush_empty", w_t'({empty, count, head_idx, enq_idx}), {1'b1, 4'd0, 3'd0, 3'd0});
        chk("flush_upd_kept", w_t'(upd_valid), 1);
        chk("flush_upd_data", upd_data, d2);
        chk("flush_bcast_off", w_t'(entry_flush_vld), 0);
        enq_req = 1'b1;
        exp_q.push_back(0);
        cyc();
        exp_q.push_back(1);
        cyc();
        enq_req = 1'b0;
        #1;
        chk("mid_count", w_t'(count), 2);
        reset_n = 1'b0;
        #1;
        chk_reset_state("async");
        exp_q.delete();
        upd_q.delete();
        #1;
        reset_n = 1'b1;
        cyc();
        enq_req = 1'b1;
        exp_q.push_back(0);
        cyc();
        enq_req = 1'b0;
        entry_ready_to_commit = 8'h01;
        head_upd_en = 1'b1;
        head_upd_data = d3;
        #3;
        chk("post_commit", w_t'(commit_valid), 1);
        upd_q.push_back(d3);
        cyc();
        entry_ready_to_commit = 8'h00;
        head_upd_en = 1'b0;
        upd_ready = 1'b1;
        #3;
        chk("post_upd_v", w_t'(upd_valid), 1);
        cyc();
        upd_ready = 1'b0;
        #3;
        chk("post_drained", w_t'(upd_valid), 0);
        chk("sb_commit_left", w_t'(exp_q.size()), 0);
        chk("sb_upd_left", w_t'(upd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
